fifo2dat_merge: RTL and testbench

Parametrised frame builder between the per-chip Intan sample FIFOs and the shared downstream data FIFO. On each `fs_fifo` strobe it drains `frame_len` bytes from every enabled input channel in ascending index order, wraps them in a header/length/checksum frame, and pushes the frame byte-serially into the data FIFO. It generalises the fixed 8-channel `fifo2adc` path with a configurable channel count and data width, a per-frame channel mask, a starve timeout with padding, and a frame checksum.

---
 rtl/fifo2dat_pkg.sv | 23 ++
 rtl/fifo2dat_pick.sv | 23 ++
 rtl/fifo2dat_merge.sv | 182 ++++++++++++++++++
 tb/tb_fifo2dat_merge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo2dat_pkg.sv
// fifo2dat_pkg: shared state encoding and counter widths for the frame merger.
// Imported by fifo2dat_merge.
package fifo2dat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_PICK,
        ST_READ,
        ST_SUM,
        ST_DONE
    } merge_st_t;

    localparam int LEN_W = 8;
    localparam int CNT_W = $clog2(1 << LEN_W);

    // Timeout counter must be able to hold the value TOUT itself.
    function automatic int tout_w(input int tout);
        return $clog2(tout + 1);
    endfunction

endpackage

// File: rtl/fifo2dat_pick.sv
// fifo2dat_pick: lowest-set-bit selector over the remaining enabled channels.
// o_none flags an empty candidate set.
module fifo2dat_pick #(
    parameter int NCH = 8,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_mask,
    output logic [IW-1:0]  o_idx,
    output logic           o_none
);

    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx  = IW'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo2dat_merge.sv
// fifo2dat_merge: drains enabled sample FIFOs channel-major into one frame
// (HEAD, length, data, XOR checksum) written byte-serially to the data FIFO.
module fifo2dat_merge
    import fifo2dat_pkg::*;
#(
    parameter int              NCH  = 8,
    parameter int              DW   = 8,
    parameter int              TOUT = 1024,
    parameter logic [DW-1:0]   HEAD = DW'(8'hA5),
    parameter logic [DW-1:0]   PAD  = DW'(8'h00)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fs_fifo,
    output logic                fd_fifo,
    output logic                err,
    input  logic [NCH-1:0]      ch_mask,
    input  logic [LEN_W-1:0]    frame_len,
    output logic [NCH-1:0]      fifoi_rxen,
    input  logic [NCH*DW-1:0]   fifoi_rxd,
    input  logic [NCH-1:0]      fifoi_empty,
    output logic                fifod_txen,
    output logic [DW-1:0]       fifod_txd,
    input  logic                fifod_full
);

    localparam int             IW   = $clog2(NCH);
    localparam int             TW   = tout_w(TOUT);
    localparam logic [TW-1:0]  TMAX = TW'(TOUT);
    localparam logic [TW-1:0]  TERR = TW'(TOUT - 1);

    merge_st_t         r_st, w_nxt;
    logic [NCH-1:0]    r_mask, r_vis;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [TW-1:0]     r_tcnt;
    logic [IW-1:0]     r_cur;
    logic              r_pend, r_dtxen, r_err;
    logic [DW-1:0]     r_data, r_csum;

    logic [IW-1:0]     w_idx;
    logic              w_none, w_remain, w_empty, w_tout;
    logic              w_rd, w_pad, w_starve, w_txen, w_fd;
    logic [NCH-1:0]    w_rxen;
    logic [DW-1:0]     w_rdat, w_txd;

    fifo2dat_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .i_mask (r_mask & ~r_vis),
        .o_idx  (w_idx),
        .o_none (w_none)
    );

    assign w_remain = (r_cnt != r_len);
    assign w_empty  = fifoi_empty[r_cur];
    assign w_tout   = (r_tcnt == TMAX);
    assign w_rdat   = fifoi_rxd[int'(r_cur)*DW +: DW];
    assign w_rd     = (r_st == ST_READ) && w_remain && !w_tout
                    && !w_empty && !fifod_full;
    assign w_pad    = (r_st == ST_READ) && w_remain && w_tout
                    && !fifod_full;
    assign w_starve = (r_st == ST_READ) && w_remain && w_empty && !w_tout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_nxt;
        end
    end

    always_comb begin
        w_nxt  = r_st;
        w_rxen = '0;
        w_txen = 1'b0;
        w_txd  = '0;
        w_fd   = 1'b0;
        unique case (r_st)
            ST_IDLE: begin
                if (fs_fifo) w_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (!fifod_full) begin
                    w_txen = 1'b1;
                    w_txd  = HEAD;
                    w_nxt  = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!fifod_full) begin
                    w_txen = 1'b1;
                    w_txd  = DW'(r_len);
                    w_nxt  = ST_PICK;
                end
            end
            ST_PICK: begin
                w_nxt = (!w_none && r_len != '0) ? ST_READ : ST_SUM;
            end
            ST_READ: begin
                w_rxen[r_cur] = w_rd;
                if (w_pad) begin
                    w_txen = 1'b1;
                    w_txd  = PAD;
                end
                // Last read was issued a cycle ago; its byte lands during PICK.
                if (!w_remain) w_nxt = ST_PICK;
            end
            ST_SUM: begin
                if (!fifod_full) begin
                    w_txen = 1'b1;
                    w_txd  = r_csum;
                    w_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_fd  = 1'b1;
                w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
        if (r_dtxen) begin
            w_txen = 1'b1;
            w_txd  = r_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask  <= '0;
            r_vis   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_cur   <= '0;
            r_pend  <= 1'b0;
            r_dtxen <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_csum  <= '0;
        end else begin
            r_pend  <= w_rd;
            r_dtxen <= r_pend;
            if (r_pend) r_data <= w_rdat;
            if (r_st == ST_IDLE && fs_fifo) begin
                r_mask <= ch_mask;
                r_len  <= frame_len;
                r_vis  <= '0;
                r_csum <= '0;
                r_err  <= 1'b0;
            end else if (r_pend) begin
                r_csum <= r_csum ^ w_rdat;
            end else if (w_pad) begin
                r_csum <= r_csum ^ PAD;
            end
            if (r_st == ST_PICK) begin
                r_cnt  <= '0;
                r_tcnt <= '0;
                if (!w_none) begin
                    r_cur        <= w_idx;
                    r_vis[w_idx] <= 1'b1;
                end
            end else begin
                if (w_rd || w_pad) r_cnt <= r_cnt + CNT_W'(1);
                if (w_rd) begin
                    r_tcnt <= '0;
                end else if (w_starve) begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (r_tcnt == TERR) r_err <= 1'b1;
                end
            end
        end
    end

    assign fifoi_rxen = w_rxen;
    assign fifod_txen = w_txen;
    assign fifod_txd  = w_txd;
    assign fd_fifo    = w_fd;
    assign err        = r_err;

endmodule

// File: tb/tb_fifo2dat_merge.sv
// tb_fifo2dat_merge: directed and random frames against a queue-based model
// of the expected frame byte stream.
module tb_fifo2dat_merge;

    localparam int NCH  = 8;
    localparam int DW   = 8;
    localparam int TOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fs_fifo = 1'b0;
    logic              fd_fifo, err, fifod_txen;
    logic              fifod_full = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [7:0]        frame_len = '0;
    logic [NCH-1:0]    fifoi_rxen;
    logic [NCH-1:0]    fifoi_empty = '1;
    logic [NCH*DW-1:0] fifoi_rxd = '0;
    logic [DW-1:0]     fifod_txd;

    fifo2dat_merge #(
        .NCH  (NCH),
        .DW   (DW),
        .TOUT (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fs_fifo     (fs_fifo),
        .fd_fifo     (fd_fifo),
        .err         (err),
        .ch_mask     (ch_mask),
        .frame_len   (frame_len),
        .fifoi_rxen  (fifoi_rxen),
        .fifoi_rxd   (fifoi_rxd),
        .fifoi_empty (fifoi_empty),
        .fifod_txen  (fifod_txen),
        .fifod_txd   (fifod_txd),
        .fifod_full  (fifod_full)
    );

    always #5 clk = ~clk;

    logic [7:0]     fq [NCH][$];
    logic [7:0]     ld [NCH][$];
    logic [7:0]     got [$];
    logic [7:0]     exp_q [$];
    logic           exp_err;
    logic [NCH-1:0] pend = '0;
    int             n_chk = 0, n_pass = 0;
    int             fd_cnt = 0, rx_cnt = 0, viol = 0;
    bit             bp_en = 1'b0;
    int             bp_ph = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    always @(negedge clk) begin
        if (fifod_txen) got.push_back(fifod_txd);
        if (fd_fifo) fd_cnt++;
        if (|fifoi_rxen) rx_cnt++;
        if ((fifod_full && |fifoi_rxen) || $countones(fifoi_rxen) > 1)
            viol++;
        for (int i = 0; i < NCH; i++)
            if (fifoi_rxen[i] && fq[i].size() == 0) viol++;
        pend = fifoi_rxen;
    end

    // Input FIFOs: data shows up the cycle after a read enable.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++)
                if (pend[i] && fq[i].size() > 0)
                    fifoi_rxd[i*DW +: DW] = fq[i].pop_front();
            for (int i = 0; i < NCH; i++)
                fifoi_empty[i] = (fq[i].size() == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bp_ph++;
                if (bp_ph == 2) begin
                    bp_ph = 0;
                    fifod_full = ~fifod_full;
                end
            end else begin
                bp_ph = 0;
                fifod_full = 1'b0;
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) begin
            fq[i].delete();
            ld[i].delete();
        end
    endtask

    task automatic load(input int ch, input logic [7:0] b);
        fq[ch].push_back(b);
        ld[ch].push_back(b);
    endtask

    // Frame = HEAD, len, each enabled channel's first len bytes (0 when the
    // channel ran dry), XOR of the data bytes.
    task automatic build_exp(input logic [NCH-1:0] m, input logic [7:0] len);
        logic [7:0] cs, b;
        cs = 8'h00;
        exp_err = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(len);
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < int'(len); k++) begin
                    if (k < ld[ch].size()) begin
                        b = ld[ch][k];
                    end else begin
                        b = 8'h00;
                        exp_err = 1'b1;
                    end
                    cs = cs ^ b;
                    exp_q.push_back(b);
                end
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_frame(input string tag, input logic [NCH-1:0] m,
                             input logic [7:0] len, input bit bp,
                             input bit inj);
        int fd0, rx0, v0, cyc;
        bit done, want, pulsed;
        build_exp(m, len);
        repeat (2) @(posedge clk);
        #1;
        ch_mask = m;
        frame_len = len;
        bp_en = bp;
        got.delete();
        fd0 = fd_cnt;
        rx0 = rx_cnt;
        v0 = viol;
        fs_fifo = 1'b1;
        @(posedge clk);
        #1;
        fs_fifo = 1'b0;
        ch_mask = ~m;
        frame_len = len + 8'd1;
        chk({tag, "_errclr"}, 32'(err), 32'd0);
        cyc = 0;
        done = 1'b0;
        want = 1'b0;
        pulsed = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            fs_fifo = inj && (cyc == 3 || want);
            if (want) begin
                want = 1'b0;
                pulsed = 1'b1;
            end
            @(negedge clk);
            #1;
            if (inj && !pulsed && got.size() >= exp_q.size()) want = 1'b1;
            if (fd_cnt != fd0) done = 1'b1;
            cyc++;
        end
        @(posedge clk);
        #1;
        fs_fifo = 1'b0;
        bp_en = 1'b0;
        if (!done) chk({tag, "_fd_wait"}, 32'd0, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_fd"}, 32'(fd_cnt - fd0), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_rxviol"}, 32'(viol - v0), 32'd0);
        if (m == '0 || len == 8'd0)
            chk({tag, "_norx"}, 32'(rx_cnt - rx0), 32'd0);
    endtask

    initial begin
        int fd0, n;
        logic [NCH-1:0] m;
        logic [7:0] len;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txen", 32'(fifod_txen), 32'd0);
        chk("rst_txd", 32'(fifod_txd), 32'd0);
        chk("rst_rxen", 32'(fifoi_rxen), 32'd0);
        chk("rst_fd", 32'(fd_fifo), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        clear_all();
        load(0, 8'h01); load(0, 8'h02); load(0, 8'h03);
        load(2, 8'h10); load(2, 8'h20); load(2, 8'h40);
        run_frame("norm", 8'h05, 8'd3, 1'b0, 1'b0);
        if (got.size() == 9) chk("norm_csum_lit", 32'(got[8]), 32'h70);

        clear_all();
        load(0, 8'h01); load(0, 8'h02); load(0, 8'h03);
        load(2, 8'h10); load(2, 8'h20); load(2, 8'h40);
        run_frame("bp", 8'h05, 8'd3, 1'b1, 1'b0);

        clear_all();
        load(0, 8'h11); load(0, 8'h22);
        run_frame("tout", 8'h01, 8'd4, 1'b0, 1'b0);

        clear_all();
        load(0, 8'h5A); load(1, 8'h6B);
        run_frame("mask0", 8'h00, 8'd4, 1'b0, 1'b0);

        clear_all();
        for (int i = 0; i < NCH; i++) load(i, 8'(i + 1));
        run_frame("len0", 8'hFF, 8'd0, 1'b0, 1'b0);

        // Reset while channel 0 is streaming.
        clear_all();
        for (int i = 0; i < 4; i++) load(0, 8'(8'hC0 + i));
        repeat (2) @(posedge clk);
        #1;
        ch_mask = 8'h01;
        frame_len = 8'd4;
        fd0 = fd_cnt;
        fs_fifo = 1'b1;
        @(posedge clk);
        #1;
        fs_fifo = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_txen", 32'(fifod_txen), 32'd1);
        chk("pre_rst_rxen", 32'(fifoi_rxen), 32'h01);
        rst = 1'b0;
        #1;
        chk("mid_rst_txen", 32'(fifod_txen), 32'd0);
        chk("mid_rst_txd", 32'(fifod_txd), 32'd0);
        chk("mid_rst_rxen", 32'(fifoi_rxen), 32'd0);
        chk("mid_rst_fd", 32'(fd_fifo), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_nofd", 32'(fd_cnt - fd0), 32'd0);
        clear_all();
        load(1, 8'h3C); load(1, 8'hC3);
        run_frame("after_rst", 8'h02, 8'd2, 1'b0, 1'b0);

        clear_all();
        load(0, 8'h01); load(0, 8'h02); load(0, 8'h03);
        load(2, 8'h10); load(2, 8'h20); load(2, 8'h40);
        run_frame("ign", 8'h05, 8'd3, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            clear_all();
            m = NCH'($urandom);
            len = 8'($urandom_range(0, 5));
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 3) == 0) n = $urandom_range(0, int'(len));
                else n = int'(len) + $urandom_range(0, 2);
                for (int k = 0; k < n; k++) load(ch, 8'($urandom));
            end
            run_frame($sformatf("rnd%0d", r), m, len,
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
